// File: rtl/decoder_pkg.sv
// Shared types for the scan/pulse one-hot decoder family.
package decoder_pkg;

  // Operating mode as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Registered controller state; remembers which mode was active last cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10,
    PULSE  = 2'b11
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] y
);

  localparam int OUT_W = 2 ** SEL_W;

  // Exactly one bit set, selected by sel.
  always_comb begin
    y      = {OUT_W{1'b0}};
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with enable, auto-scan and timed pulse.
// Build option: define DECODER_SCAN_EN to include the scan mode (dwell
// counter, wrap strobe). Without it, mode 01 acts as direct and wrap is 0.
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int DWELL     = 4,
  parameter int PULSE_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int PW_W  = $clog2(PULSE_LEN) + 1;

  localparam logic [PW_W-1:0]  PW_ZERO = PW_W'(0);
  localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);
  localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PULSE_LEN - 1);

  // Reject nonsensical timing parameters at elaboration.
  if ((DWELL < 1) || (PULSE_LEN < 1)) begin : g_param_check
    $error("decoder_scan_nto2n: DWELL and PULSE_LEN must be >= 1");
  end

  mode_t              mode_s;
  state_t             state_r;
  state_t             state_nx_s;
  logic [SEL_W-1:0]   idx_r;
  logic [SEL_W-1:0]   idx_nx_s;
  logic               busy_r;
  logic               busy_nx_s;
  logic [PW_W-1:0]    pcnt_r;
  logic [PW_W-1:0]    pcnt_nx_s;
  logic               y_on_s;
  logic [OUT_W-1:0]   dec_s;
  logic [OUT_W-1:0]   y_nx_s;
  logic [OUT_W-1:0]   y_r;

`ifdef DECODER_SCAN_EN
  localparam int DW_W = $clog2(DWELL) + 1;

  localparam logic [DW_W-1:0]  DW_ZERO  = DW_W'(0);
  localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

  logic [DW_W-1:0] dwell_r;
  logic [DW_W-1:0] dwell_nx_s;
  logic            wrap_r;
  logic            wrap_nx_s;
`endif

  assign mode_s = mode_t'(mode);

  // Next-state, next-index and counter decisions for every mode.
  always_comb begin
    state_nx_s = IDLE;
    idx_nx_s   = idx_r;
    busy_nx_s  = 1'b0;
    pcnt_nx_s  = PW_ZERO;
    y_on_s     = 1'b0;
`ifdef DECODER_SCAN_EN
    dwell_nx_s = DW_ZERO;
    wrap_nx_s  = 1'b0;
`endif
    if (!en) begin
      // Disabled: outputs blank, index held, any pulse aborted.
      state_nx_s = IDLE;
    end else begin
      case (mode_s)
        MODE_DIRECT: begin
          state_nx_s = DIRECT;
          idx_nx_s   = sel;
          y_on_s     = 1'b1;
        end
`ifdef DECODER_SCAN_EN
        MODE_SCAN: begin
          state_nx_s = SCAN;
          y_on_s     = 1'b1;
          if (state_r != SCAN) begin
            // Entry: start at sel with a fresh dwell count.
            idx_nx_s = sel;
          end else if (dwell_r == DW_LAST) begin
            idx_nx_s  = idx_r + IDX_ONE;
            wrap_nx_s = (idx_r == IDX_LAST);
          end else begin
            dwell_nx_s = dwell_r + DW_ONE;
          end
        end
`else
        MODE_SCAN: begin
          state_nx_s = DIRECT;
          idx_nx_s   = sel;
          y_on_s     = 1'b1;
        end
`endif
        MODE_PULSE: begin
          state_nx_s = PULSE;
          if ((state_r == PULSE) && busy_r && (pcnt_r != PW_ZERO)) begin
            // Pulse still running; load is ignored.
            busy_nx_s = 1'b1;
            pcnt_nx_s = pcnt_r - PW_ONE;
            y_on_s    = 1'b1;
          end else if (load) begin
            // Idle or final pulse cycle: accept a new trigger with no gap.
            idx_nx_s  = sel;
            busy_nx_s = 1'b1;
            pcnt_nx_s = PW_LAST;
            y_on_s    = 1'b1;
          end else begin
            busy_nx_s = 1'b0;
            y_on_s    = 1'b0;
          end
        end
        MODE_RSVD: begin
          state_nx_s = IDLE;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (idx_nx_s),
    .y   (dec_s)
  );

  // Blank the decoded index unless the chosen mode drives an output.
  always_comb begin
    if (y_on_s) begin
      y_nx_s = dec_s;
    end else begin
      y_nx_s = {OUT_W{1'b0}};
    end
  end

  // State, index, pulse counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {SEL_W{1'b0}};
      busy_r  <= 1'b0;
      pcnt_r  <= PW_ZERO;
      y_r     <= {OUT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      busy_r  <= busy_nx_s;
      pcnt_r  <= pcnt_nx_s;
      y_r     <= y_nx_s;
    end
  end

`ifdef DECODER_SCAN_EN
  // Dwell counter and wrap strobe registers for scan mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_r <= DW_ZERO;
      wrap_r  <= 1'b0;
    end else begin
      dwell_r <= dwell_nx_s;
      wrap_r  <= wrap_nx_s;
    end
  end

  assign wrap = wrap_r;
`else
  assign wrap = 1'b0;
`endif

  assign y    = y_r;
  assign idx  = idx_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed self-checking bench for decoder_scan_nto2n (SEL_W=2, DWELL=2, PULSE_LEN=3).
module tb_decoder_scan_nto2n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel;
  logic       load;
  logic [3:0] y;
  logic [1:0] idx;
  logic       busy;
  logic       wrap;

  int tests;
  int fails;

  decoder_scan_nto2n #(
    .SEL_W     (2),
    .DWELL     (2),
    .PULSE_LEN (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .sel  (sel),
    .load (load),
    .y    (y),
    .idx  (idx),
    .busy (busy),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] y_e, input logic [1:0] idx_e,
                     input logic busy_e, input logic wrap_e);
    tests++;
    assert (y === y_e) else begin
      fails++;
      $error("FAIL %s y: observed %b expected %b", tag, y, y_e);
    end
    tests++;
    assert (idx === idx_e) else begin
      fails++;
      $error("FAIL %s idx: observed %0d expected %0d", tag, idx, idx_e);
    end
    tests++;
    assert (busy === busy_e) else begin
      fails++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, busy_e);
    end
    tests++;
    assert (wrap === wrap_e) else begin
      fails++;
      $error("FAIL %s wrap: observed %b expected %b", tag, wrap, wrap_e);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = 2'd0; load = 1'b0;

    // Reset
    tick(); tick();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Direct decode of every channel
    rst = 1'b0; en = 1'b1; mode = 2'b00;
    sel = 2'd0; tick(); chk("direct0", 4'b0001, 2'd0, 1'b0, 1'b0);
    sel = 2'd1; tick(); chk("direct1", 4'b0010, 2'd1, 1'b0, 1'b0);
    sel = 2'd2; tick(); chk("direct2", 4'b0100, 2'd2, 1'b0, 1'b0);
    sel = 2'd3; tick(); chk("direct3", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Enable low holds idx; reserved mode blanks output
    en = 1'b0; sel = 2'd2; tick(); chk("en_low", 4'b0000, 2'd3, 1'b0, 1'b0);
    en = 1'b1; mode = 2'b11; tick(); chk("mode_rsvd", 4'b0000, 2'd3, 1'b0, 1'b0);

`ifdef DECODER_SCAN_EN
    // Scan from channel 2 with wrap; sel changes ignored while scanning
    mode = 2'b01; sel = 2'd2; tick(); chk("scan_c2a", 4'b0100, 2'd2, 1'b0, 1'b0);
    sel = 2'd0; tick(); chk("scan_c2b", 4'b0100, 2'd2, 1'b0, 1'b0);
    tick(); chk("scan_c3a", 4'b1000, 2'd3, 1'b0, 1'b0);
    tick(); chk("scan_c3b", 4'b1000, 2'd3, 1'b0, 1'b0);
    tick(); chk("scan_wrap", 4'b0001, 2'd0, 1'b0, 1'b1);
    tick(); chk("scan_c0b", 4'b0001, 2'd0, 1'b0, 1'b0);
    tick(); chk("scan_c1a", 4'b0010, 2'd1, 1'b0, 1'b0);
`else
    // Scan mode compiled out: mode 01 decodes sel directly, no wrap
    mode = 2'b01; sel = 2'd1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("noscan", 4'b0010, 2'd1, 1'b0, 1'b0);
    end
`endif

    // Pulse of 3 cycles; load during cycle 2 ignored
    mode = 2'b10; sel = 2'd1; load = 1'b1;
    tick(); chk("pulse_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    load = 1'b0; sel = 2'd3;
    tick(); chk("pulse_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
    load = 1'b1;
    tick(); chk("pulse_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
    load = 1'b0;
    tick(); chk("pulse_end", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick(); chk("pulse_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Back-to-back: load on the last pulse cycle retriggers with no gap
    sel = 2'd2; load = 1'b1;
    tick(); chk("b2b_a1", 4'b0100, 2'd2, 1'b1, 1'b0);
    load = 1'b0;
    tick(); chk("b2b_a2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("b2b_a3", 4'b0100, 2'd2, 1'b1, 1'b0);
    sel = 2'd0; load = 1'b1;
    tick(); chk("b2b_b1", 4'b0001, 2'd0, 1'b1, 1'b0);
    load = 1'b0;
    tick(); chk("b2b_b2", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Abort pulse by switching to direct
    mode = 2'b00; sel = 2'd3;
    tick(); chk("abort_pulse", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Enter mode 01 then reset mid-operation; reset wins over en/mode
    mode = 2'b01; sel = 2'd1;
    tick(); chk("scan_entry", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); chk("scan_hold", 4'b0010, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); chk("scan_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; mode = 2'b00; sel = 2'd2;
    tick(); chk("post_rst", 4'b0100, 2'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_scan_nto2n.md
# decoder_scan_nto2n

Registered, parametrised N-to-2^N one-hot decoder with enable. It is the successor to the team's 2-to-4 enable decoder, generalised in select width and extended with two sequential modes: auto-scan, which walks the outputs at a fixed dwell, and timed pulse, which gives a one-shot output of fixed length. It sits between control logic and per-channel strobe/select lines, such as row drivers and bank enables.

## Interface
Parameters:
- SEL_W, 2, select width; OUT_W = 2**SEL_W is a derived localparam, not overridable
- DWELL, 4, cycles each channel stays active in scan mode (>=1)
- PULSE_LEN, 3, cycles the output stays asserted in pulse mode (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable
- mode  in  2  00 direct, 01 scan, 10 pulse, 11 reserved
- sel  in  SEL_W  channel select (direct/pulse), start channel (scan)
- load  in  1  pulse trigger, sampled in pulse mode only
- y  out  OUT_W  registered one-hot output, all-zero when inactive
- idx  out  SEL_W  registered index of currently selected channel
- busy  out  1  high while a pulse is in progress
- wrap  out  1  one-cycle strobe when scan index wraps OUT_W-1 -> 0

## Operation
- State machine (registered) has four states: IDLE, DIRECT, SCAN, PULSE.
- rst: state=IDLE, y=0, idx=0, busy=0, wrap=0, dwell and pulse counters=0.
- en=0 in any state:
  - Next cycle y=0, busy=0, wrap=0, state=IDLE.
  - idx holds its value.
  - An in-flight pulse is aborted.
- en=1, mode=00 (DIRECT): y <= onehot(sel), idx <= sel every cycle.
- en=1, mode=01 (SCAN):
  - Entry from any other state loads idx <= sel, dwell=0, and drives y=onehot(sel) next cycle.
  - dwell then increments each cycle. At dwell=DWELL-1, dwell clears and idx increments, wrapping OUT_W-1 -> 0.
  - wrap=1 only on the cycle y first shows channel 0 after a wrap.
  - sel changes are ignored while in SCAN.
- en=1, mode=10 (PULSE):
  - From IDLE/PULSE-not-busy: load=1 captures sel into idx, sets busy=1 and y=onehot(sel) for exactly PULSE_LEN cycles, then y=0, busy=0.
  - load while busy is ignored (no retrigger).
  - load on the cycle busy falls is accepted: back-to-back pulses with no gap.
- mode=11: treated as en=0 (y=0, state IDLE).
- Mode change mid-operation: aborts the current scan/pulse and enters the new mode as on entry. busy clears the same cycle y updates.
- At most one bit of y is ever set.

## Timing
- Latency is 1 cycle from sampled inputs to y/idx/busy/wrap in every mode; there are no combinational input-to-output paths.
- Scan period: each channel holds for exactly DWELL cycles; a full cycle is OUT_W*DWELL cycles. With DWELL=1, idx advances every cycle.
- Pulse: load sampled at edge k gives y nonzero for edges k+1 .. k+PULSE_LEN.
- rst has priority over en, mode and load on the same edge.
- Counter widths: dwell uses $clog2(DWELL)+1 bits, pulse counter uses $clog2(PULSE_LEN)+1 bits. No overflow is possible.

## Configuration
- DECODER_SCAN_EN defined: SCAN state, dwell counter and wrap logic are built as described.
- DECODER_SCAN_EN undefined:
  - SCAN logic is not synthesised.
  - mode=01 behaves as DIRECT.
  - wrap is tied to 0.
  - DWELL is unused.

## Structure
- Shared package decoder_pkg holds:
  - mode_t enum (MODE_DIRECT, MODE_SCAN, MODE_PULSE, MODE_RSVD)
  - state_t enum (IDLE, DIRECT, SCAN, PULSE)
- Sub-module onehot_dec (parameter SEL_W): combinational sel -> OUT_W one-hot, instantiated once and fed by a next-idx mux.
- Top holds the FSM, counters and output registers.

## Test plan
All scenarios use SEL_W=2, DWELL=2, PULSE_LEN=3.
- Reset, then direct: rst=1 for 2 cycles -> y=0000, busy=0, idx=0. Then en=1, mode=00, sel=0,1,2,3 -> y=0001,0010,0100,1000 one cycle later each.
- Enable low: en=0, mode=00, sel=2 -> y=0000 next cycle, idx holds 3; mode=11 with en=1 -> y=0000.
- Scan wrap: en=1, mode=01, sel=2 -> y=0100 for 2 cycles, then 1000 for 2, then 0001 with wrap=1 for one cycle, then 0010.
- Pulse and no-retrigger: mode=10, sel=1, load=1 for one cycle -> y=0010, busy=1 for exactly 3 cycles, then 0000. A load on cycle 2 of the pulse is ignored; a load on the cycle busy falls gives the next pulse back-to-back.
- Abort: mid-pulse assert mode=00, sel=3 -> next cycle y=1000, busy=0. Mid-scan assert rst -> y=0000, idx=0 next cycle.
- Macro off (DECODER_SCAN_EN undefined): mode=01, sel=1 -> y=0010 steadily, wrap never asserts.
